// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory load/store stage with valid/ready request and rvalid response (optional LSU_MISALIGN_TRAP_EN)
module load_store_unit #(
    parameter int TIMEOUT = 255,
    parameter int TCW     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        done,
    output logic        bus_err,
    output logic        fault,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Last counter value before a silent WAIT is abandoned; unused when TIMEOUT is 0.
    localparam logic [TCW-1:0] TO_LAST = TCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t         state_q, state_d;
    logic           write_q, write_d;
    logic [2:0]     f3_q, f3_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [TCW-1:0] cnt_q, cnt_d;
    logic           err_q, err_d;

    logic [3:0]     be_w;
    logic [31:0]    wdata_w;
    logic [31:0]    load_w;
    logic [7:0]     lane_b;
    logic [15:0]    lane_h;

`ifdef LSU_MISALIGN_TRAP_EN
    logic           fault_q, fault_d;
    logic           misalign;

    // Misalignment of the incoming request, judged before anything is issued.
    always_comb begin
        case (funct3[1:0])
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = addr[0];
            default: misalign = (addr[1:0] != 2'b00);
        endcase
    end

    assign fault = (state_q == S_DONE) && fault_q;
`else
    assign fault = 1'b0;
`endif

    // Byte enables, lane-replicated store data and extended load data from the latched request.
    always_comb begin
        be_w    = 4'b1111;
        wdata_w = wdata_q;
        case (addr_q[1:0])
            2'b00:   lane_b = mem_rdata[7:0];
            2'b01:   lane_b = mem_rdata[15:8];
            2'b10:   lane_b = mem_rdata[23:16];
            default: lane_b = mem_rdata[31:24];
        endcase
        lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_w = mem_rdata;
        case (f3_q[1:0])
            2'b00: begin
                be_w    = 4'b0001 << addr_q[1:0];
                wdata_w = {4{wdata_q[7:0]}};
                load_w  = {{24{~f3_q[2] & lane_b[7]}}, lane_b};
            end
            2'b01: begin
                be_w    = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_w = {2{wdata_q[15:0]}};
                load_w  = {{16{~f3_q[2] & lane_h[15]}}, lane_h};
            end
            default: begin
                be_w    = 4'b1111;
                wdata_w = wdata_q;
                load_w  = mem_rdata;
            end
        endcase
    end

    // Next-state, request latching, response capture and timeout for the access FSM.
    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        f3_d      = f3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cnt_d     = '0;
        err_d     = err_q;
`ifdef LSU_MISALIGN_TRAP_EN
        fault_d   = fault_q;
`endif
        stall     = 1'b0;
        mem_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall = req_valid;
                if (req_valid) begin
                    write_d = req_write;
                    f3_d    = funct3;
                    addr_d  = addr;
                    wdata_d = wdata;
                    err_d   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                    fault_d = misalign;
                    state_d = misalign ? S_DONE : S_REQ;
`else
                    state_d = S_REQ;
`endif
                end
            end
            S_REQ: begin
                stall     = 1'b1;
                mem_valid = 1'b1;
                if (mem_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q + TCW'(1);
                if (mem_rvalid) begin
                    if (!write_q) begin
                        rdata_d = load_w;
                    end
                    state_d = S_DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef LSU_MISALIGN_TRAP_EN
            fault_q <= fault_d;
`endif
        end
    end

    // Request fields are driven only while a request is offered so the bus idles at zero.
    assign mem_we    = mem_valid & write_q;
    assign mem_addr  = mem_valid ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_be    = mem_valid ? be_w : 4'b0000;
    assign mem_wdata = mem_valid ? wdata_w : 32'h0;
    assign done      = (state_q == S_DONE);
    assign bus_err   = (state_q == S_DONE) && err_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - table-driven bench for load_store_unit
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        done;
    logic        bus_err;
    logic        fault;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    load_store_unit #(.TIMEOUT(4), .TCW(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .funct3(funct3),
        .addr(addr), .wdata(wdata),
        .stall(stall), .rdata(rdata), .done(done), .bus_err(bus_err), .fault(fault),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rw;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vt [11];

    logic        obs_valid_seen, obs_unstable, obs_we;
    logic [31:0] obs_addr, obs_wdata, obs_rdata;
    logic [3:0]  obs_be;
    logic        obs_done, obs_err, obs_fault, obs_stall_done, obs_done_after, obs_valid_after;
    int          obs_stall_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Entered on a negedge with the DUT idle; returns one negedge after the DONE cycle.
    task automatic run_access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rw,
                              input int rdy_dly, input int rv_dly);
        int cyc;
        int req_cycles;
        int wait_cycles;
        req_valid = 1'b1; req_write = w; funct3 = f3; addr = a; wdata = wd;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = rw;
        #1;
        obs_stall_cnt  = stall ? 1 : 0;
        obs_valid_seen = 1'b0; obs_unstable = 1'b0; obs_done = 1'b0;
        obs_err = 1'b0; obs_fault = 1'b0; obs_stall_done = 1'b1;
        obs_we = 1'b0; obs_addr = '0; obs_be = '0; obs_wdata = '0; obs_rdata = '0;
        cyc = 0; req_cycles = 0; wait_cycles = 0;
        while (!obs_done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                obs_done = 1'b1; obs_err = bus_err; obs_fault = fault;
                obs_rdata = rdata; obs_stall_done = stall;
            end else begin
                if (stall) obs_stall_cnt++;
                if (mem_valid) begin
                    if (!obs_valid_seen) begin
                        obs_we = mem_we; obs_addr = mem_addr; obs_be = mem_be; obs_wdata = mem_wdata;
                    end else if (mem_we !== obs_we || mem_addr !== obs_addr ||
                                 mem_be !== obs_be || mem_wdata !== obs_wdata) begin
                        obs_unstable = 1'b1;
                    end
                    obs_valid_seen = 1'b1;
                    req_cycles++;
                    mem_ready  = (req_cycles > rdy_dly);
                    mem_rvalid = (rdy_dly > 0);
                    mem_rdata  = 32'h0BAD0BAD;
                end else begin
                    mem_ready = 1'b0;
                    if (obs_valid_seen) begin
                        wait_cycles++;
                        mem_rvalid = (rv_dly >= 0) && (wait_cycles > rv_dly);
                        mem_rdata  = rw;
                    end else begin
                        mem_rvalid = 1'b0;
                    end
                end
            end
        end
        req_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        obs_done_after  = done;
        obs_valid_after = mem_valid;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 32'h100, 4'b1111, 32'h0,        32'hDEADBEEF};
        vt[1]  = '{1'b0, 3'b000, 32'h103, 32'h0,        32'h80018000, 32'h100, 4'b1000, 32'h0,        32'hFFFFFF80};
        vt[2]  = '{1'b0, 3'b100, 32'h103, 32'h0,        32'h80018000, 32'h100, 4'b1000, 32'h0,        32'h00000080};
        vt[3]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'h80018000, 32'h100, 4'b1100, 32'h0,        32'hFFFF8001};
        vt[4]  = '{1'b0, 3'b101, 32'h100, 32'h0,        32'h80018000, 32'h100, 4'b0011, 32'h0,        32'h00008000};
        vt[5]  = '{1'b1, 3'b000, 32'h201, 32'h000000AB, 32'h55555555, 32'h200, 4'b0010, 32'hABABABAB, 32'h00008000};
        vt[6]  = '{1'b1, 3'b001, 32'h202, 32'h00001234, 32'h55555555, 32'h200, 4'b1100, 32'h12341234, 32'h00008000};
        vt[7]  = '{1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h55555555, 32'h300, 4'b1111, 32'hCAFEF00D, 32'h00008000};
        vt[8]  = '{1'b0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 32'h100, 4'b0010, 32'h0,        32'h0000007F};
        vt[9]  = '{1'b0, 3'b011, 32'h104, 32'h0,        32'h12345678, 32'h104, 4'b1111, 32'h0,        32'h12345678};
        vt[10] = '{1'b0, 3'b001, 32'h100, 32'h0,        32'hFFFF7FFF, 32'h100, 4'b0011, 32'h0,        32'h00007FFF};

        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; funct3 = 3'b000;
        addr = '0; wdata = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);
        chk("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mem_be", {28'h0, mem_be}, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            run_access(vt[i].w, vt[i].f3, vt[i].a, vt[i].wd, vt[i].rw, 0, 0);
            chk($sformatf("v%0d_done", i), {31'h0, obs_done}, 32'h1);
            chk($sformatf("v%0d_addr", i), obs_addr, vt[i].e_addr);
            chk($sformatf("v%0d_be", i), {28'h0, obs_be}, {28'h0, vt[i].e_be});
            chk($sformatf("v%0d_we", i), {31'h0, obs_we}, {31'h0, vt[i].w});
            chk($sformatf("v%0d_wdata", i), obs_wdata, vt[i].e_wdata);
            chk($sformatf("v%0d_rdata", i), obs_rdata, vt[i].e_rdata);
            chk($sformatf("v%0d_stall_cycles", i), obs_stall_cnt, 32'd3);
            chk($sformatf("v%0d_stall_in_done", i), {31'h0, obs_stall_done}, 32'h0);
            chk($sformatf("v%0d_bus_err", i), {31'h0, obs_err}, 32'h0);
            chk($sformatf("v%0d_fault", i), {31'h0, obs_fault}, 32'h0);
            chk($sformatf("v%0d_done_pulse", i), {31'h0, obs_done_after}, 32'h0);
        end

        // mem_ready held low for 5 REQ cycles, with stray rvalid during REQ.
        run_access(1'b0, 3'b010, 32'h180, 32'h0, 32'h11223344, 5, 0);
        chk("stall_req_stable", {31'h0, obs_unstable}, 32'h0);
        chk("stall_req_addr", obs_addr, 32'h180);
        chk("stall_req_be", {28'h0, obs_be}, 32'hF);
        chk("stall_req_cycles", obs_stall_cnt, 32'd8);
        chk("stall_req_rdata", obs_rdata, 32'h11223344);
        chk("stall_req_done", {31'h0, obs_done}, 32'h1);

        // No response: abort after 4 WAIT cycles.
        run_access(1'b0, 3'b010, 32'h400, 32'h0, 32'h99999999, 0, -1);
        chk("timeout_done", {31'h0, obs_done}, 32'h1);
        chk("timeout_bus_err", {31'h0, obs_err}, 32'h1);
        chk("timeout_rdata", obs_rdata, 32'h0);
        chk("timeout_stall_cycles", obs_stall_cnt, 32'd6);
        chk("timeout_done_pulse", {31'h0, obs_done_after}, 32'h0);
        chk("timeout_idle_valid", {31'h0, obs_valid_after}, 32'h0);
        chk("timeout_idle_stall", {31'h0, stall}, 32'h0);
        @(negedge clk);
        chk("timeout_err_pulse", {31'h0, bus_err}, 32'h0);

        // Reset during WAIT abandons the access; a late rvalid is ignored.
        run_access(1'b0, 3'b010, 32'h104, 32'h0, 32'hA5A5A5A5, 0, 0);
        chk("pre_reset_rdata", obs_rdata, 32'hA5A5A5A5);
        req_valid = 1'b1; req_write = 1'b0; funct3 = 3'b010; addr = 32'h500;
        @(negedge clk);
        chk("mid_reset_in_req", {31'h0, mem_valid}, 32'h1);
        mem_ready = 1'b1;
        @(negedge clk);
        chk("mid_reset_in_wait", {31'h0, stall & ~mem_valid}, 32'h1);
        mem_ready = 1'b0; reset = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
        #1;
        chk("mid_reset_stall", {31'h0, stall}, 32'h0);
        chk("mid_reset_valid", {31'h0, mem_valid}, 32'h0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("late_rvalid_done", {31'h0, done}, 32'h0);
        chk("late_rvalid_rdata", rdata, 32'h0);
        chk("late_rvalid_stall", {31'h0, stall}, 32'h0);
        @(negedge clk);
        chk("late_rvalid_done2", {31'h0, done}, 32'h0);

        // Misaligned word load.
        run_access(1'b0, 3'b010, 32'h102, 32'h0, 32'h3C3C3C3C, 0, 0);
        chk("misalign_done", {31'h0, obs_done}, 32'h1);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("misalign_fault", {31'h0, obs_fault}, 32'h1);
        chk("misalign_no_valid", {31'h0, obs_valid_seen}, 32'h0);
        chk("misalign_rdata", obs_rdata, 32'h0);
        chk("misalign_stall_cycles", obs_stall_cnt, 32'd1);
`else
        chk("misalign_fault", {31'h0, obs_fault}, 32'h0);
        chk("misalign_addr", obs_addr, 32'h100);
        chk("misalign_be", {28'h0, obs_be}, 32'hF);
        chk("misalign_rdata", obs_rdata, 32'h3C3C3C3C);
`endif
        chk("misalign_done_pulse", {31'h0, obs_done_after}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
